control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Main control unit of the multi-cycle RV32I core. A Moore FSM steps each instruction
//  through FETCH/DECODE/EXECUTE/MEM/WB. It drives all datapath mux selects and write
//  enables, the ALU operation, and immsrc[2:0] for the immediate extender.
//  Sits between the instruction register (op/funct fields), ALU zero flag and memory ready.
// PARAMETERS
//  HAS_MEMREADY  1  1: FETCH/MEMREAD/MEMWRITE wait for memready; 0: memready ignored (treated 1)
//  BNE_EN        1  1: branch polarity from funct3[0] (bne); 0: beq only (take = zero)
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  synchronous, active-high
//  op          in   7  instr[6:0] from instruction register
//  funct3      in   3  instr[14:12]
//  funct7b5    in   1  instr[30]
//  zero        in   1  ALU result == 0
//  memready    in   1  memory completes access this cycle
//  immsrc      out  3  000 I, 001 S, 010 B, 011 J, 100 U (decoded from op only)
//  alusrca     out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
//  alusrcb     out  2  00 RD2, 01 ImmExt, 10 const 4
//  resultsrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  adrsrc      out  1  memory address: 0 PC, 1 Result
//  alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  irwrite / pcwrite / regwrite / memwrite  out 1 each  write enables
//  illegal     out  1  one-cycle pulse: unsupported opcode seen in DECODE
//  state_o     out  4  current state encoding (debug)
// BEHAVIOUR
//  - reset: state <= FETCH (0) on the clock edge. While reset is high, irwrite, pcwrite, regwrite,
//    memwrite and illegal are forced to 0. After reset, the first FETCH starts the next cycle.
//  - immsrc is combinational on op: lw/OP-IMM/jalr -> 000, sw -> 001, branch -> 010,
//    jal -> 011, lui/auipc -> 100, others -> 000.
//  - Each state emits fixed selects; unlisted selects are 00; aluop defaults to 00.
//  - FETCH   : adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10, aluop 00. If memready:
//              irwrite=1, pcupdate=1, go to DECODE. Otherwise hold FETCH with enables at 0.
//  - DECODE  : alusrca=01, alusrcb=01 (branch target). Next state by op:
//              0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI;
//              1101111 -> JAL; 1100011 -> BRANCH; 0110111 -> LUI; 0010111 -> AUIPC;
//              any other op -> illegal=1, go to FETCH.
//  - MEMADR  : alusrca=10, alusrcb=01. lw goes to MEMREAD; sw goes to MEMWRITE.
//  - MEMREAD : resultsrc=00, adrsrc=1. Wait for memready, then go to MEMWB.
//  - MEMWB   : resultsrc=01, regwrite=1, go to FETCH.
//  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1 held until memready, then go to FETCH.
//  - EXECR: alusrca=10, alusrcb=00, aluop 10, go to ALUWB.
//  - EXECI: alusrca=10, alusrcb=01, aluop 10, go to ALUWB.
//  - ALUWB   : resultsrc=00, regwrite=1, go to FETCH.
//  - JAL     : alusrca=01, alusrcb=10, resultsrc=00, pcupdate=1, go to ALUWB (rd = PC+4).
//  - BRANCH  : alusrca=10, alusrcb=00, aluop 01, resultsrc=00, branch=1, go to FETCH.
//  - LUI: alusrca=11, alusrcb=01, go to ALUWB. AUIPC: alusrca=01, alusrcb=01, go to ALUWB.
//  - pcwrite = pcupdate | (branch & take). take = zero ^ (BNE_EN & funct3[0]).
//  - ALU decode (alucontrol):
//      aluop 00 -> add; aluop 01 -> sub.
//      aluop 10, by funct3: 000 -> sub if (op[5] & funct7b5), else add; 010 -> slt;
//      110 -> or; 111 -> and; other funct3 -> add.
//  - Every write enable is 0 in every state where it is not listed above.
//  - Cycle counts with memready tied high: lw=5, sw=4, R/I/lui/auipc/jal=4, branch=3.
//  - reset mid-instruction: aborts immediately, no write enable seen after reset; restart at FETCH.
//  - Unreachable state encodings go to FETCH on the next clock.
// TESTING
//  1. Reset, then lw (op 0000011), memready=1. Required states: FETCH, DECODE, MEMADR,
//     MEMREAD, MEMWB. irwrite in cycle 1 only; regwrite in cycle 5 only; resultsrc=01 in MEMWB.
//  2. sw with memready low for 3 cycles in MEMWRITE. memwrite stays 1 for 4 cycles with
//     adrsrc=1; FETCH follows; immsrc=001 throughout.
//  3. beq (funct3 000): zero=1 -> pcwrite=1 in BRANCH; zero=0 -> pcwrite=0.
//     bne (funct3 001), zero=0 -> pcwrite=1. In both, alucontrol=001 and immsrc=010.
//  4. R-type, funct3 000, funct7b5=1 -> alucontrol=001 in EXECR. Same with funct7b5=0 ->
//     000. I-type addi with funct7b5=1 -> 000.
//  5. lui: alusrca=11, alusrcb=01, immsrc=100, regwrite in ALUWB. op 1111111 -> illegal
//     pulses 1 cycle in DECODE, no write enables, back to FETCH.
//  6. Assert reset during MEMWRITE while memready is low. memwrite=0 in the reset cycle,
//     state_o=0 afterwards, next FETCH waits for memready.

Source files
------------

// File: rtl/control_fsm.sv
// control_fsm: main control unit of the multi-cycle RV32I core.
// A Moore FSM steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives
// the datapath mux selects, the write enables, the ALU operation and the immediate type.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op, funct3,       instruction fields from the instruction register
//   funct7b5
//   zero              ALU result == 0 (branch decision)
//   memready          memory completes its access this cycle
//   immsrc            immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
//   alusrca/alusrcb   ALU operand selects
//   resultsrc         result mux select
//   adrsrc            memory address select (0 PC, 1 Result)
//   alucontrol        ALU operation
//   irwrite, pcwrite,
//   regwrite, memwrite  write enables
//   illegal           one-cycle pulse on an unsupported opcode in DECODE
//   state_o           current state encoding (debug)
module control_fsm #(
    parameter bit HAS_MEMREADY = 1'b1,
    parameter bit BNE_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       memready,
    output logic [2:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic       memReady;
    logic       take;
    logic       pcUpdate, branch;
    logic       irWriteRaw, regWriteRaw, memWriteRaw, illegalRaw;
    logic [1:0] aluOp;

    // Without a handshaking memory every access completes in one cycle.
    assign memReady = HAS_MEMREADY ? memready : 1'b1;

    // bne inverts the sense of the zero flag when enabled.
    assign take = zero ^ (BNE_EN & funct3[0]);

    // State register; the reset edge always returns to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

    // Immediate format depends only on the opcode.
    always_comb begin
        immsrc = 3'b000;
        case (op)
            7'b0100011:             immsrc = 3'b001;
            7'b1100011:             immsrc = 3'b010;
            7'b1101111:             immsrc = 3'b011;
            7'b0110111, 7'b0010111: immsrc = 3'b100;
            default:                immsrc = 3'b000;
        endcase
    end

    // Per-state selects, raw enables and next state.
    always_comb begin
        state_d     = S_FETCH;
        alusrca     = 2'b00;
        alusrcb     = 2'b00;
        resultsrc   = 2'b00;
        adrsrc      = 1'b0;
        aluOp       = 2'b00;
        pcUpdate    = 1'b0;
        branch      = 1'b0;
        irWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        memWriteRaw = 1'b0;
        illegalRaw  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                if (memReady) begin
                    irWriteRaw = 1'b1;
                    pcUpdate   = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b0110111:             state_d = S_LUI;
                    7'b0010111:             state_d = S_AUIPC;
                    default: begin
                        illegalRaw = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                // op[5] separates store (0100011) from load (0000011).
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = memReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                resultsrc   = 2'b01;
                regWriteRaw = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc      = 1'b1;
                memWriteRaw = 1'b1;
                state_d     = memReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regWriteRaw = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BRANCH: begin
                alusrca = 2'b10;
                aluOp   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_LUI: begin
                alusrca = 2'b11;
                alusrcb = 2'b01;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset suppresses every enable, including in the cycle it is first raised.
    assign irwrite  = irWriteRaw & ~reset;
    assign pcwrite  = (pcUpdate | (branch & take)) & ~reset;
    assign regwrite = regWriteRaw & ~reset;
    assign memwrite = memWriteRaw & ~reset;
    assign illegal  = illegalRaw & ~reset;

    // ALU decoder; subtract for R-type only, since addi reuses funct7 bits as immediate.
    always_comb begin
        alucontrol = 3'b000;
        case (aluOp)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed bench for control_fsm with hand-computed expectations.
// Inputs change just after the falling edge and outputs are sampled 1ns later,
// well away from the rising edge that advances the state.
module tb_control_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       memready;
    logic [2:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;
    logic [3:0] state_o;

    int compared;
    int mismatched;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    control_fsm #(.HAS_MEMREADY(1'b1), .BNE_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .memready   (memready),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    // 10ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle, drive inputs, let combinational outputs settle.
    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic mr);
        @(negedge clk);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        memready = mr;
        #1;
    endtask

    // State plus the enable vector {irwrite, pcwrite, regwrite, memwrite, illegal}.
    task automatic checkCycle(input string tag, input logic [3:0] expState, input logic [4:0] expEn);
        checkOutput({tag, ".state"}, 32'(state_o), 32'(expState));
        checkOutput({tag, ".en"}, 32'({irwrite, pcwrite, regwrite, memwrite, illegal}), 32'(expEn));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        op         = OP_LW;
        funct3     = 3'b010;
        funct7b5   = 1'b0;
        zero       = 1'b0;
        memready   = 1'b1;

        // Reset: enables held low even though FETCH would fire with memready high.
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("rst", 4'd0, 5'b00000);
        reset = 1'b0;
        #1;

        // lw: FETCH DECODE MEMADR MEMREAD MEMWB.
        checkCycle("lw.fetch", 4'd0, 5'b11000);
        checkOutput("lw.fetch.srcb", 32'(alusrcb), 32'd2);
        checkOutput("lw.fetch.res", 32'(resultsrc), 32'd2);
        checkOutput("lw.fetch.adr", 32'(adrsrc), 32'd0);
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("lw.decode", 4'd1, 5'b00000);
        checkOutput("lw.decode.srcab", 32'({alusrca, alusrcb}), 32'b0101);
        checkOutput("lw.imm", 32'(immsrc), 32'd0);
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("lw.memadr", 4'd2, 5'b00000);
        checkOutput("lw.memadr.srcab", 32'({alusrca, alusrcb}), 32'b1001);
        checkOutput("lw.memadr.alu", 32'(alucontrol), 32'd0);
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("lw.memread", 4'd3, 5'b00000);
        checkOutput("lw.memread.adr", 32'(adrsrc), 32'd1);
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("lw.memwb", 4'd4, 5'b00100);
        checkOutput("lw.memwb.res", 32'(resultsrc), 32'd1);

        // sw with memready low for 3 cycles in MEMWRITE.
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("sw.fetch", 4'd0, 5'b11000);
        checkOutput("sw.imm.fetch", 32'(immsrc), 32'd1);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("sw.decode", 4'd1, 5'b00000);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("sw.memadr", 4'd2, 5'b00000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, (i == 3));
            checkCycle($sformatf("sw.memwrite%0d", i), 4'd5, 5'b00010);
            checkOutput($sformatf("sw.adr%0d", i), 32'(adrsrc), 32'd1);
            checkOutput($sformatf("sw.imm%0d", i), 32'(immsrc), 32'd1);
        end

        // beq taken, beq not taken, bne taken.
        for (int k = 0; k < 3; k++) begin
            logic [2:0] f3;
            logic       z;
            logic [4:0] en;
            f3 = (k == 2) ? 3'b001 : 3'b000;
            z  = (k == 0);
            en = (k == 1) ? 5'b00000 : 5'b01000;
            applyStimulus(OP_BR, f3, 1'b0, z, 1'b1);
            checkCycle($sformatf("br%0d.fetch", k), 4'd0, 5'b11000);
            applyStimulus(OP_BR, f3, 1'b0, z, 1'b1);
            checkCycle($sformatf("br%0d.decode", k), 4'd1, 5'b00000);
            checkOutput($sformatf("br%0d.imm", k), 32'(immsrc), 32'd2);
            applyStimulus(OP_BR, f3, 1'b0, z, 1'b1);
            checkCycle($sformatf("br%0d.branch", k), 4'd10, en);
            checkOutput($sformatf("br%0d.alu", k), 32'(alucontrol), 32'd1);
        end

        // R-type sub, R-type add, addi with funct7b5 set, R-type or.
        for (int k = 0; k < 4; k++) begin
            logic [6:0] o;
            logic [2:0] f3;
            logic       f7;
            logic [3:0] exState;
            logic [2:0] exAlu;
            o       = (k == 2) ? OP_I : OP_R;
            f3      = (k == 3) ? 3'b110 : 3'b000;
            f7      = (k != 1);
            exState = (k == 2) ? 4'd7 : 4'd6;
            exAlu   = (k == 0) ? 3'b001 : ((k == 3) ? 3'b011 : 3'b000);
            applyStimulus(o, f3, f7, 1'b0, 1'b1);
            checkCycle($sformatf("alu%0d.fetch", k), 4'd0, 5'b11000);
            applyStimulus(o, f3, f7, 1'b0, 1'b1);
            checkCycle($sformatf("alu%0d.decode", k), 4'd1, 5'b00000);
            applyStimulus(o, f3, f7, 1'b0, 1'b1);
            checkCycle($sformatf("alu%0d.exec", k), exState, 5'b00000);
            checkOutput($sformatf("alu%0d.alu", k), 32'(alucontrol), 32'(exAlu));
            applyStimulus(o, f3, f7, 1'b0, 1'b1);
            checkCycle($sformatf("alu%0d.aluwb", k), 4'd8, 5'b00100);
        end

        // jal: PC update in JAL, then write-back of PC+4.
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
        checkCycle("jal.fetch", 4'd0, 5'b11000);
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
        checkOutput("jal.imm", 32'(immsrc), 32'd3);
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
        checkCycle("jal.jal", 4'd9, 5'b01000);
        checkOutput("jal.srcab", 32'({alusrca, alusrcb}), 32'b0110);
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
        checkCycle("jal.aluwb", 4'd8, 5'b00100);

        // lui.
        applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1);
        checkCycle("lui.fetch", 4'd0, 5'b11000);
        applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1);
        checkCycle("lui.decode", 4'd1, 5'b00000);
        applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1);
        checkCycle("lui.lui", 4'd11, 5'b00000);
        checkOutput("lui.srcab", 32'({alusrca, alusrcb}), 32'b1101);
        checkOutput("lui.imm", 32'(immsrc), 32'd4);
        applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1);
        checkCycle("lui.aluwb", 4'd8, 5'b00100);

        // Unsupported opcode: one illegal pulse in DECODE, then straight back to FETCH.
        applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1);
        checkCycle("bad.fetch", 4'd0, 5'b11000);
        applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1);
        checkCycle("bad.decode", 4'd1, 5'b00001);
        applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b0);
        checkCycle("bad.refetch", 4'd0, 5'b00000);

        // Reset while a store is stalled in MEMWRITE.
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("rsw.fetch", 4'd0, 5'b11000);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        checkCycle("rsw.memwrite", 4'd5, 5'b00010);
        reset = 1'b1;
        #1;
        checkCycle("rsw.resetcycle", 4'd5, 5'b00000);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkCycle("rsw.after", 4'd0, 5'b00000);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        checkCycle("rsw.wait", 4'd0, 5'b00000);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("rsw.fetch2", 4'd0, 5'b11000);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        checkCycle("rsw.decode2", 4'd1, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
